// File: rtl/whack_score_accum.sv
// Two-stage whack-a-mole score accumulator: S1 counts hits and picks the combo
// multiplier, S2 adds points into a saturating score. WHACK_PENALTY_EN subtracts unlit whacks.
module whack_score_accum #(
    parameter int N_HOLES   = 18,
    parameter int SCORE_W   = 11,
    parameter int MAX_COMBO = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         round_valid,
    input  logic [N_HOLES-1:0]           led,
    input  logic [N_HOLES-1:0]           whacked,
    input  logic                         clear,
    output logic [SCORE_W-1:0]           score,
    output logic [3:0]                   combo,
    output logic [$clog2(N_HOLES+1)-1:0] last_hits,
    output logic                         score_valid,
    output logic                         saturated
);
    localparam int HW   = $clog2(N_HOLES + 1);
    localparam int PW   = HW + 4;
    localparam int SUMW = ((PW > SCORE_W) ? PW : SCORE_W) + 1;
    localparam logic [4:0]      MAXC = 5'(MAX_COMBO);
    localparam logic [SUMW-1:0] MAXV = {{(SUMW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic [HW-1:0] popcount(input logic [N_HOLES-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N_HOLES; i++) c = c + HW'(v[i]);
        return c;
    endfunction

    logic [0:0]         state_q, state_d;
    logic [HW-1:0]      hits_q, hits_d;
    logic [3:0]         mult_q, mult_d;
    logic [3:0]         combo_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [HW-1:0]      last_hits_q;
    logic               score_valid_q, sat_q, clip;

    logic [N_HOLES-1:0] hit_mask;
    logic               any_lit, full;
    logic [4:0]         combo_inc;
    logic [PW-1:0]      points;
    logic [SUMW-1:0]    sum, clipped;

    assign hit_mask  = led & whacked;
    assign any_lit   = |led;
    assign full      = any_lit && (hit_mask == led);
    assign combo_inc = {1'b0, combo_q} + 5'd1;

    // An empty round reuses the current combo as its multiplier so the combo register holds.
    always_comb begin
        hits_d = popcount(hit_mask);
        mult_d = 4'd1;
        if (!any_lit)
            mult_d = combo_q;
        else if (full && combo_q != 4'd0)
            mult_d = (combo_inc > MAXC) ? MAXC[3:0] : combo_inc[3:0];
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = round_valid ? BUSY : IDLE;
            BUSY:    state_d = round_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WHACK_PENALTY_EN
    logic [HW-1:0] misses_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misses_q <= '0;
        else if (round_valid)
            misses_q <= popcount(whacked & ~led);
    end
`endif

    assign points  = PW'(hits_q) * PW'(mult_q);
    assign sum     = SUMW'(score_q) + SUMW'(points);
    assign clip    = sum > MAXV;
    assign clipped = clip ? MAXV : sum;

`ifdef WHACK_PENALTY_EN
    // Penalty applies after the upper clip and floors at zero; it never sets saturated.
    always_comb begin
        if (clipped < SUMW'(misses_q))
            score_d = '0;
        else
            score_d = SCORE_W'(clipped - SUMW'(misses_q));
    end
`else
    always_comb score_d = clipped[SCORE_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hits_q  <= '0;
            mult_q  <= '0;
            combo_q <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            combo_q <= '0;
        end else begin
            state_q <= state_d;
            if (round_valid) begin
                hits_q  <= hits_d;
                mult_q  <= mult_d;
                combo_q <= mult_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q       <= '0;
            last_hits_q   <= '0;
            score_valid_q <= 1'b0;
            sat_q         <= 1'b0;
        end else if (clear) begin
            score_q       <= '0;
            last_hits_q   <= '0;
            score_valid_q <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            score_valid_q <= (state_q == BUSY);
            if (state_q == BUSY) begin
                score_q     <= score_d;
                last_hits_q <= hits_q;
                if (clip) sat_q <= 1'b1;
            end
        end
    end

    assign score       = score_q;
    assign combo       = combo_q;
    assign last_hits   = last_hits_q;
    assign score_valid = score_valid_q;
    assign saturated   = sat_q;

endmodule

// File: tb/tb_whack_score_accum.sv
// Scoreboard bench for whack_score_accum: driver queues hand-computed results,
// a negedge monitor compares them against each score_valid pulse.
module tb_whack_score_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        round_valid;
    logic [17:0] led, whacked;
    logic        clear;
    logic [10:0] score;
    logic [3:0]  combo;
    logic [4:0]  last_hits;
    logic        score_valid, saturated;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int score;
        int hits;
        int sat;
    } exp_t;
    exp_t q[$];

    whack_score_accum #(.N_HOLES(18), .SCORE_W(11), .MAX_COMBO(5)) dut (
        .clk(clk), .rst_n(rst_n), .round_valid(round_valid), .led(led),
        .whacked(whacked), .clear(clear), .score(score), .combo(combo),
        .last_hits(last_hits), .score_valid(score_valid), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every score_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (score_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_score_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("score", int'(score), e.score);
                chk("last_hits", int'(last_hits), e.hits);
                chk("saturated", int'(saturated), e.sat);
            end
        end
    end

    task automatic do_round(input logic [17:0] l, input logic [17:0] w,
                            input int es, input int eh, input int ec, input int esat);
        exp_t e;
        @(negedge clk);
        led = l; whacked = w; round_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("combo", int'(combo), ec);
        e.score = es; e.hits = eh; e.sat = esat;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        round_valid = 1'b0; led = '0; whacked = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_combo"}, int'(combo), 0);
        chk({tag, "_last_hits"}, int'(last_hits), 0);
        chk({tag, "_score_valid"}, int'(score_valid), 0);
        chk({tag, "_saturated"}, int'(saturated), 0);
    endtask

    task automatic do_clear();
        idle(3);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check_zero("clear");
        @(negedge clk);
        clear = 1'b0;
    endtask

    int ramp_score[6] = '{3, 9, 18, 30, 45, 60};
    int ramp_combo[6] = '{1, 2, 3, 4, 5, 5};
    int s, sat, m;

    initial begin
        rst_n = 1'b0; round_valid = 1'b0; led = '0; whacked = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            do_round(18'h00007, 18'h00007, ramp_score[i], 3, ramp_combo[i], 0);
        do_round(18'h0000F, 18'h00003, 62, 2, 1, 0);
`ifdef WHACK_PENALTY_EN
        do_round(18'h00000, 18'h3FFFF, 44, 0, 1, 0);
`else
        do_round(18'h00000, 18'h3FFFF, 62, 0, 1, 0);
`endif

        // Clear colliding with a round: the round must vanish.
        do_clear();
        for (int i = 0; i < 6; i++)
            do_round(18'h00007, 18'h00007, ramp_score[i], 3, ramp_combo[i], 0);
        idle(3);
        chk("pre_clear_score", int'(score), 60);
        led = 18'h1; whacked = 18'h1; round_valid = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        check_zero("collide");
        @(negedge clk);
        clear = 1'b0; round_valid = 1'b0;
        @(negedge clk);
        chk("collide_no_pulse", int'(score_valid), 0);
        do_round(18'h1, 18'h1, 1, 1, 1, 0);

        // Saturation: 18 hits per round with the ramping combo, clipping at 2047.
        do_clear();
        s = 0; sat = 0;
        for (int i = 1; i <= 27; i++) begin
            m = (i < 5) ? i : 5;
            s = s + 18 * m;
            if (s > 2047) begin s = 2047; sat = 1; end
            do_round(18'h3FFFF, 18'h3FFFF, s, 18, m, sat);
        end
        idle(3);
        chk("sat_hold_score", int'(score), 2047);
        chk("sat_hold_flag", int'(saturated), 1);

        // Reset one cycle after a round is accepted: the round is lost.
        do_round(18'h7, 18'h7, 0, 0, 5, 1);
        void'(q.pop_back());
        @(negedge clk);
        round_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

`ifdef WHACK_PENALTY_EN
        do_round(18'h1, 18'h3, 0, 1, 1, 0);
`else
        do_round(18'h1, 18'h3, 1, 1, 1, 0);
`endif
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/whack_score_accum.md
# whack_score_accum

Parametrised round-based score accumulator for the whack-a-mole game. It sits between the LED pattern generator and the score display. Once per completed round it sees the lit-hole mask and the whacked-hole mask, counts valid hits, applies a capped combo multiplier, and adds the result to a saturating score. The block is pipelined so that it accepts one round per clock.

## Interface
- N_HOLES, 18: number of holes (LED/switch pairs), 1..32
- SCORE_W, 11: score width; score saturates at 2^SCORE_W-1
- MAX_COMBO, 5: multiplier cap, 1..15
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- round_valid  in  1  single-cycle strobe: led/whacked hold a completed round
- led  in  N_HOLES  lit-hole mask for the round
- whacked  in  N_HOLES  hit-hole mask for the round
- clear  in  1  synchronous restart: zero score, combo and flags
- score  out  SCORE_W  accumulated score
- combo  out  4  multiplier applied to the last accepted round (0 = none yet)
- last_hits  out  $clog2(N_HOLES+1)  hit count of the last scored round
- score_valid  out  1  one-cycle pulse, score updated this cycle
- saturated  out  1  sticky: score has clipped at its maximum

## Operation
- hits = popcount(led & whacked). Whacks on unlit holes never add points.
- full = (led != 0) && ((led & whacked) == led).
- The multiplier mult is chosen as follows:
  - full and combo==0: mult = 1
  - full and combo>0: mult = min(combo+1, MAX_COMBO)
  - led != 0 and not full (miss): mult = 1
  - led == 0: mult = combo, hits = 0; the combo is held and no points are added
- points = hits*mult is computed at width $clog2(N_HOLES+1)+4, with no truncation.
- Score update: new = score + points, computed SCORE_W+1 wide (widened further if points is wider).
  - If new > 2^SCORE_W-1: score = 2^SCORE_W-1 and saturated is set.
- Pipeline:
  - S1 registers hits, mult and s1_valid.
  - S2 performs the add/saturate and pulses score_valid.
- Stage control state: IDLE (s1_valid=0) and BUSY (s1_valid=1).
  - IDLE -> BUSY on round_valid.
  - BUSY stays BUSY on round_valid.
  - BUSY -> IDLE otherwise.
- The combo register updates in S1, so consecutive rounds see the correct combo without a stall.

## Timing
- Reset values: score=0, combo=0, last_hits=0, score_valid=0, saturated=0, s1_valid=0.
- Latency: round_valid sampled at edge k -> score, last_hits and score_valid=1 visible after edge k+1.
  - combo is visible after edge k.
- Throughput: one round per cycle. There is no backpressure and no round is dropped.
- clear=1 at an edge:
  - All outputs return to reset values.
  - s1_valid is cleared and any round in S1 is discarded.
  - A round_valid in the same cycle is discarded; clear wins.
- Reset asserted mid-pipeline: in-flight rounds are lost and outputs go to reset values immediately.
- Once saturated, further rounds keep score at its maximum and still pulse score_valid. Only clear or reset drops the saturated flag.
- round_valid=0: led and whacked are don't-care.

## Configuration
- WHACK_PENALTY_EN defined:
  - misses = popcount(whacked & ~led).
  - S2 computes score = max(min(score+points, max) - misses, 0).
  - The saturated flag is set only by the upper clip.
  - Penalties do not affect the combo.
- Not defined: unlit whacks are ignored and the subtract/floor logic is absent.

## Test plan
- Combo ramp. Defaults; six rounds of led=0x00007, whacked=0x00007, back-to-back.
  - Points 3,6,9,12,15,15; final score=60, combo=5, six score_valid pulses.
- Miss reset. Continue with led=0x0000F, whacked=0x00003.
  - last_hits=2, combo=1, score=62.
- Empty round. Continue with led=0, whacked=0x3FFFF.
  - score stays 62, combo stays 1, score_valid pulses.
  - Without the macro, score is unchanged; with WHACK_PENALTY_EN, score=44.
- Saturation. Defaults; repeat led=whacked=0x3FFFF.
  - Scores 18,54,108,180,270,360,...
  - Score clamps at 2047 with saturated=1 on the clipping round and stays there on later rounds.
- Clear collision. score=60, then clear=1 together with round_valid=1 (led=whacked=0x1).
  - Next cycle: score=0, combo=0, no score_valid.
  - Next round led=whacked=0x1 gives score=1, combo=1.
- Reset mid-flight and penalty.
  - Assert rst_n=0 one cycle after round_valid: score_valid never pulses and all outputs read 0.
  - With WHACK_PENALTY_EN, led=0x1, whacked=0x3 from score=0 gives score=0 (floor), combo=1.
